// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, mem_port_arbiter and the memory.
// master = arbiter side; slave = requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;

    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic              mem_stall;
    logic              mem_done;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    modport master (
        input  if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
               mem_stall, mem_done, mem_rdata,
        output if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );

    modport slave (
        output if_req, if_addr, d_req, d_wr, d_addr, d_wdata,
               mem_stall, mem_done, mem_rdata,
        input  if_done, if_rdata, if_stall, d_done, d_rdata, d_stall,
               mem_addr, mem_wdata, mem_rd, mem_wr, err
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one stall-capable memory port between instruction fetch and the data stage.
// Data has strict priority; a WAIT that outlives MAX_WAIT cycles sets a sticky err.
module mem_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_WAIT = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);
    localparam int               CNT_W    = $clog2(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic       {OWN_I, OWN_D}            owner_t;

    state_t            state_q;
    owner_t            owner_q;
    logic              wr_q;
    logic              mem_rd_q;
    logic              mem_wr_q;
    logic              if_done_q;
    logic              d_done_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_I;
            wr_q       <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            d_done_q   <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    // mem_done seen here belongs to nobody and is dropped
                    if (bus.d_req) begin
                        addr_q   <= bus.d_addr;
                        wdata_q  <= bus.d_wdata;
                        wr_q     <= bus.d_wr;
                        owner_q  <= OWN_D;
                        mem_rd_q <= ~bus.d_wr;
                        mem_wr_q <= bus.d_wr;
                        state_q  <= S_ISSUE;
                    end else if (bus.if_req) begin
                        addr_q   <= bus.if_addr;
                        wr_q     <= 1'b0;
                        owner_q  <= OWN_I;
                        mem_rd_q <= 1'b1;
                        mem_wr_q <= 1'b0;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!bus.mem_stall) begin
                        mem_rd_q <= 1'b0;
                        mem_wr_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.mem_done) begin
                        if (owner_q == OWN_D) begin
                            d_done_q <= 1'b1;
                            if (!wr_q) begin
                                d_rdata_q <= bus.mem_rdata;
                            end
                        end else begin
                            if_done_q  <= 1'b1;
                            if_rdata_q <= bus.mem_rdata;
                        end
                        state_q <= S_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        // Abandon silently; the still-held request is reissued from IDLE
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_done    = d_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.err       = err_q;
    assign bus.if_stall  = bus.if_req & ~if_done_q;
    assign bus.d_stall   = bus.d_req & ~d_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised bench for mem_port_arbiter: a transaction-level model predicts owner,
// strobe timing, done cycle, read data and the sticky timeout flag.
module tb_mem_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // mem_m: what the memory should hold by the model; dev_m: the bench's memory device
    logic [15:0] mem_m [0:1023];
    logic [15:0] dev_m [0:1023];
    logic [15:0] exp_if_rdata = '0;
    logic [15:0] exp_d_rdata  = '0;
    logic        exp_err      = 1'b0;

    bit          pend_i = 1'b0;
    bit          pend_d = 1'b0;
    logic [15:0] i_addr = '0;
    logic [15:0] d_addr_m = '0;
    logic [15:0] d_wdata_m = '0;
    bit          d_wr_m = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One access from an IDLE cycle (cycle 0) through its done / timeout cycle.
    task automatic run_access(input int stall, input int lat, input bit tmo, input bit drop);
        bit          own_d, wr, cur_i, cur_d, hit, idn, ddn, md;
        logic [15:0] a, cap;
        logic [6:0]  obs, exp_v;
        int          w;
        own_d = pend_d;
        wr    = pend_d && d_wr_m;
        a     = own_d ? d_addr_m : i_addr;
        cur_i = pend_i;
        cur_d = pend_d;
        cap   = '0;
        hit   = 1'b0;
        bus.if_req    = pend_i;
        bus.d_req     = pend_d;
        bus.if_addr   = i_addr;
        bus.d_addr    = d_addr_m;
        bus.d_wdata   = d_wdata_m;
        bus.d_wr      = d_wr_m;
        bus.mem_stall = 1'($urandom_range(0, 1));
        bus.mem_done  = 1'($urandom_range(0, 1));
        bus.mem_rdata = 16'($urandom);
        tick();
        // Inputs after sampling must not matter
        bus.if_addr = 16'($urandom);
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = 16'($urandom);
        for (int cyc = 1; !hit && cyc <= stall + 1 + MW; cyc++) begin
            w = cyc - stall - 2;
            if (drop && cyc == 2) begin
                if (own_d) begin
                    cur_d = 1'b0; pend_d = 1'b0; bus.d_req = 1'b0;
                end else begin
                    cur_i = 1'b0; pend_i = 1'b0; bus.if_req = 1'b0;
                end
            end
            if (w < 0) begin
                bus.mem_stall = (cyc <= stall);
                bus.mem_done  = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
            end else begin
                md            = !tmo && (w == lat);
                bus.mem_stall = 1'($urandom_range(0, 1));
                bus.mem_done  = md;
                bus.mem_rdata = md ? dev_m[cap[9:0]] : 16'($urandom);
                hit           = md || (w == MW - 1);
            end
            #1;
            exp_v = {(w < 0) && !wr, (w < 0) && wr, 2'b00, exp_err, cur_i, cur_d};
            obs   = {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err, bus.if_stall, bus.d_stall};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL ctl cyc=%0d rd,wr,ifd,dd,err,ifs,ds got=%b want=%b", cyc, obs, exp_v);
            end
            n_tests++;
            if (bus.mem_addr !== a || (wr && bus.mem_wdata !== d_wdata_m)) begin
                n_fail++;
                $display("FAIL addr cyc=%0d got=%h/%h want=%h/%h", cyc, bus.mem_addr, bus.mem_wdata, a, d_wdata_m);
            end
            n_tests++;
            if ({bus.if_rdata, bus.d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
                n_fail++;
                $display("FAIL rdata_hold cyc=%0d got=%h/%h want=%h/%h", cyc, bus.if_rdata, bus.d_rdata,
                         exp_if_rdata, exp_d_rdata);
            end
            if (w < 0) begin
                cap = bus.mem_addr;
                if (bus.mem_wr && !bus.mem_stall) dev_m[bus.mem_addr[9:0]] = bus.mem_wdata;
            end
            tick();
        end
        bus.mem_done = 1'b0;
        if (tmo) exp_err = 1'b1;
        else if (own_d) begin
            if (wr) mem_m[a[9:0]] = d_wdata_m;
            else    exp_d_rdata = mem_m[a[9:0]];
        end else exp_if_rdata = mem_m[a[9:0]];
        idn = !tmo && !own_d;
        ddn = !tmo && own_d;
        #1;
        exp_v = {2'b00, idn, ddn, exp_err, cur_i && !idn, cur_d && !ddn};
        obs   = {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err, bus.if_stall, bus.d_stall};
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL done_cycle rd,wr,ifd,dd,err,ifs,ds got=%b want=%b", obs, exp_v);
        end
        n_tests++;
        if ({bus.if_rdata, bus.d_rdata} !== {exp_if_rdata, exp_d_rdata}) begin
            n_fail++;
            $display("FAIL done_rdata got=%h/%h want=%h/%h", bus.if_rdata, bus.d_rdata, exp_if_rdata, exp_d_rdata);
        end
        if (!tmo) begin
            if (own_d) begin pend_d = 1'b0; bus.d_req = 1'b0; end
            else begin pend_i = 1'b0; bus.if_req = 1'b0; end
        end
    endtask

    task automatic test_reset();
        bus.if_req = 0; bus.d_req = 0; bus.d_wr = 0; bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.mem_stall = 0; bus.mem_done = 0; bus.mem_rdata = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err, bus.if_stall, bus.d_stall} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctl got=%b want=0", {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got=%h want=0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
        end
        bus.d_req = 1'b1;
        #1;
        n_tests++;
        if ({bus.if_stall, bus.d_stall} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_stall got=%b want=01", {bus.if_stall, bus.d_stall});
        end
        bus.d_req = 1'b0;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        mem_m[16] = 16'hC1A5; dev_m[16] = 16'hC1A5;
        pend_i = 1; i_addr = 16'h0010;
        run_access(0, 0, 0, 0);
        repeat (2) begin
            tick();
            n_tests++;
            if (bus.if_rdata !== 16'hC1A5 || bus.if_done !== 1'b0) begin
                n_fail++;
                $display("FAIL single_fetch_hold got=%h done=%b want=c1a5 done=0", bus.if_rdata, bus.if_done);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] keep;
        keep = exp_d_rdata;
        pend_i = 1; i_addr = 16'h0030;
        pend_d = 1; d_wr_m = 1; d_addr_m = 16'h0200; d_wdata_m = 16'hBEEF;
        run_access(0, 1, 0, 0);
        run_access(0, 0, 0, 0);
        n_tests++;
        if (bus.d_rdata !== keep || dev_m[512] !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL simultaneous d_rdata=%h want=%h mem=%h want=beef", bus.d_rdata, keep, dev_m[512]);
        end
    endtask

    task automatic test_mem_stall();
        pend_d = 1; d_wr_m = 0; d_addr_m = 16'h0040;
        run_access(3, 0, 0, 0);
        n_tests++;
        if (bus.d_rdata !== mem_m[64]) begin
            n_fail++;
            $display("FAIL mem_stall d_rdata got=%h want=%h", bus.d_rdata, mem_m[64]);
        end
    endtask

    task automatic test_dropped_request();
        pend_d = 1; d_wr_m = 0; d_addr_m = 16'($urandom_range(0, 1023));
        run_access(0, 1, 0, 1);
        repeat (3) begin
            bus.mem_done = 1'($urandom_range(0, 1));
            bus.mem_rdata = 16'($urandom);
            tick();
            n_tests++;
            if ({bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done} !== 4'b0 || bus.d_rdata !== exp_d_rdata) begin
                n_fail++;
                $display("FAIL dropped_no_reissue got=%b rdata=%h want=0000 rdata=%h",
                         {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done}, bus.d_rdata, exp_d_rdata);
            end
        end
        bus.mem_done = 1'b0;
    endtask

    task automatic test_timeout();
        pend_i = 1; i_addr = 16'h0077;
        run_access(0, 0, 1, 0);
        run_access(1, 2, 0, 0);
        n_tests++;
        if (bus.err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky err got=%b want=1", bus.err);
        end
    endtask

    task automatic test_random(input int n);
        bit tmo;
        for (int it = 0; it < n; it++) begin
            if (!pend_i && $urandom_range(0, 2) != 0) begin
                pend_i = 1; i_addr = 16'($urandom_range(0, 1023));
            end
            if (!pend_d && $urandom_range(0, 2) == 0) begin
                pend_d = 1; d_addr_m = 16'($urandom_range(0, 1023));
                d_wdata_m = 16'($urandom); d_wr_m = 1'($urandom_range(0, 1));
            end
            if (pend_i || pend_d) begin
                tmo = ($urandom_range(0, 9) == 0);
                run_access(int'($urandom_range(0, 3)), int'($urandom_range(0, MW - 1)), tmo,
                           !tmo && ($urandom_range(0, 5) == 0));
            end else begin
                bus.if_req = 0; bus.d_req = 0;
                bus.mem_done = 1'($urandom_range(0, 1));
                bus.mem_rdata = 16'($urandom);
                tick();
                n_tests++;
                if ({bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err} !== {4'b0, exp_err}) begin
                    n_fail++;
                    $display("FAIL idle_quiet got=%b want=%b", {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done,
                             bus.err}, {4'b0, exp_err});
                end
            end
        end
        bus.mem_done = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        pend_i = 1; pend_d = 0; i_addr = 16'h0123;
        bus.if_req = 1; bus.if_addr = i_addr; bus.d_req = 0; bus.mem_stall = 0; bus.mem_done = 0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        n_tests++;
        if ({bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err, bus.if_stall} !== 6'b000001) begin
            n_fail++;
            $display("FAIL async_reset_ctl got=%b want=000001",
                     {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err, bus.if_stall});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL async_reset_data got=%h want=0", {bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.d_rdata});
        end
        bus.if_req = 0; pend_i = 0;
        exp_if_rdata = '0; exp_d_rdata = '0; exp_err = 1'b0;
        #1 rst = 1'b1;
        repeat (3) begin
            bus.mem_done = 1'b1;
            bus.mem_rdata = 16'($urandom);
            tick();
            n_tests++;
            if ({bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err} !== 5'b0 || bus.if_rdata !== 16'h0) begin
                n_fail++;
                $display("FAIL late_mem_done got=%b rdata=%h want=00000 rdata=0000",
                         {bus.mem_rd, bus.mem_wr, bus.if_done, bus.d_done, bus.err}, bus.if_rdata);
            end
        end
        bus.mem_done = 1'b0;
    endtask

    task automatic test_back_to_back();
        pend_i = 1; i_addr = 16'h0100;
        run_access(0, 0, 0, 0);
        pend_i = 1; i_addr = 16'h0104;
        run_access(0, 0, 0, 0);
        n_tests++;
        if (bus.if_rdata !== mem_m[260]) begin
            n_fail++;
            $display("FAIL back_to_back if_rdata got=%h want=%h", bus.if_rdata, mem_m[260]);
        end
    endtask

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 1024; i++) begin
            v = 16'($urandom);
            mem_m[i] = v;
            dev_m[i] = v;
        end
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_mem_stall();
        test_dropped_request();
        test_random(60);
        test_timeout();
        test_random(40);
        test_reset_mid_wait();
        test_back_to_back();
        test_random(30);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
